// File: rtl/and3_sweep_checker.sv
// and3_sweep_checker
// Consumer stage for a 3-bit stepping stimulus generator driving a 3-input
// AND gate under test. After `start` it aligns to the 111->000 wrap, then
// checks one full 000..111 sweep for sequence, hold length and gate logic.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   in0, in1, in2    : stimulus pattern bits 2, 1, 0
//   out              : gate-under-test output
//   start            : one-cycle run request (accepted in IDLE and DONE)
//   busy             : run in progress (ALIGN or CHECK)
//   done, pass       : run finished / finished with zero errors
//   err_cnt          : saturating error count for this run
//   vec_cnt          : patterns completed this run (0..8)
//   err_code         : most recent error class (0 none, 1 logic, 2 seq/step, 3 timeout)
module and3_sweep_checker #(
    parameter int unsigned STEP    = 2,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0,
    input  logic             in1,
    input  logic             in2,
    input  logic             out,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       vec_cnt,
    output logic [1:0]       err_code
);

    localparam int unsigned HOLD_W = $clog2(TIMEOUT + 1);
    localparam int unsigned VEC_W  = 4;

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_LOGIC   = 2'd1;
    localparam logic [1:0] CODE_SEQ     = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         pat_q, pat_d;
    logic [2:0]         pat_dly_q, pat_dly_d;
    logic               o_s_q, o_s_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               mm_flag_q, mm_flag_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [VEC_W-1:0]   vec_cnt_q, vec_cnt_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic               change;
    logic               mm_now;
    logic               mm_flag_eff;
    logic               seq_bad;
    logic               timeout;
    logic               err_hit;
    logic [1:0]         err_class;
    logic               start_run;

    // Next-state, check and counter logic
    always_comb begin
        pat_d      = {in0, in1, in2};
        o_s_d      = out;
        pat_dly_d  = pat_q;

        state_d    = state_q;
        err_cnt_d  = err_cnt_q;
        vec_cnt_d  = vec_cnt_q;
        err_code_d = err_code_q;
        err_hit    = 1'b0;
        err_class  = CODE_NONE;
        start_run  = 1'b0;

        change      = (pat_q != pat_dly_q);
        mm_now      = (o_s_q != (&pat_q));
        // The per-pattern mismatch flag belongs to the previous pattern on a change
        mm_flag_eff = change ? 1'b0 : mm_flag_q;
        mm_flag_d   = mm_flag_eff;
        seq_bad     = (pat_q != 3'(pat_dly_q + 3'd1)) ||
                      (hold_cnt_q != HOLD_W'(STEP));
        timeout     = (hold_cnt_q == HOLD_W'(TIMEOUT)) && !change;

        if (change) begin
            hold_cnt_d = HOLD_W'(1);
        end else if (hold_cnt_q < HOLD_W'(TIMEOUT)) begin
            hold_cnt_d = HOLD_W'(hold_cnt_q + HOLD_W'(1));
        end else begin
            hold_cnt_d = hold_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_run = 1'b1;
                end
            end
            S_ALIGN: begin
                if (timeout) begin
                    err_hit   = 1'b1;
                    err_class = CODE_TIMEOUT;
                    state_d   = S_DONE;
                end else if (change && (pat_dly_q == 3'b111) && (pat_q == 3'b000)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (timeout) begin
                    err_hit   = 1'b1;
                    err_class = CODE_TIMEOUT;
                    state_d   = S_DONE;
                end else begin
                    if (mm_now) begin
                        mm_flag_d = 1'b1;
                        if (!mm_flag_eff) begin
                            err_hit   = 1'b1;
                            err_class = CODE_LOGIC;
                        end
                    end
                    if (change) begin
                        vec_cnt_d = VEC_W'(vec_cnt_q + VEC_W'(1));
                        // Sequence/step outranks a same-cycle mismatch; still one error
                        if (seq_bad) begin
                            err_hit   = 1'b1;
                            err_class = CODE_SEQ;
                        end
                        if (vec_cnt_q == VEC_W'(7)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    start_run = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (err_hit) begin
            err_code_d = err_class;
            if (err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_d = CNT_W'(err_cnt_q + CNT_W'(1));
            end
        end

        // A new run starts from a clean slate
        if (start_run) begin
            state_d    = S_ALIGN;
            err_cnt_d  = '0;
            vec_cnt_d  = '0;
            err_code_d = CODE_NONE;
            hold_cnt_d = '0;
            mm_flag_d  = 1'b0;
        end

        busy_d = (state_d == S_ALIGN) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_cnt_d == '0);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pat_q      <= '0;
            pat_dly_q  <= '0;
            o_s_q      <= 1'b0;
            hold_cnt_q <= '0;
            mm_flag_q  <= 1'b0;
            err_cnt_q  <= '0;
            vec_cnt_q  <= '0;
            err_code_q <= CODE_NONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            pat_dly_q  <= pat_dly_d;
            o_s_q      <= o_s_d;
            hold_cnt_q <= hold_cnt_d;
            mm_flag_q  <= mm_flag_d;
            err_cnt_q  <= err_cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign vec_cnt  = vec_cnt_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_and3_sweep_checker.sv
// Bench for and3_sweep_checker: drives pattern/hold lists through a modelled
// gate truth table and compares run results against a list-level reference.
module tb_and3_sweep_checker;

    localparam int unsigned STEP    = 2;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in0, in1, in2, out, start;
    logic             busy, done, pass;
    logic [CNT_W-1:0] err_cnt;
    logic [3:0]       vec_cnt;
    logic [1:0]       err_code;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         pats[$];
    int         holds[$];
    logic [7:0] tt;

    always #5 clk = ~clk;

    and3_sweep_checker #(.STEP(STEP), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2), .out(out),
        .start(start), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .vec_cnt(vec_cnt), .err_code(err_code)
    );

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_pat(input int p);
        logic [2:0] p3;
        p3 = 3'(p);
        {in0, in1, in2} = p3;
        out = tt[p3];
    endtask

    function automatic bit gate_wrong(input int p);
        logic [2:0] p3;
        p3 = 3'(p);
        return tt[p3] != (p3 == 3'b111);
    endfunction

    // Reference: align on the first 7->0 in the list, then each later entry is one
    // completed pattern; an entry costs one error if it breaks the +1 sequence, its
    // predecessor was held for other than STEP cycles, or the gate is wrong on it.
    task automatic model(output int a, output int fin, output int ecnt, output int ecode);
        int  vec;
        bit  seq, mm;
        a = -1;
        for (int i = 1; i < pats.size(); i++)
            if (a < 0 && pats[i-1] == 7 && pats[i] == 0) a = i;
        ecnt = 0; ecode = 0; fin = -1; vec = 0;
        if (gate_wrong(pats[a])) begin ecnt++; ecode = 1; end
        for (int i = a + 1; i < pats.size() && fin < 0; i++) begin
            seq = (pats[i] != (pats[i-1] + 1) % 8) || (holds[i-1] != int'(STEP));
            mm  = gate_wrong(pats[i]);
            vec++;
            if (seq || mm) begin ecnt++; ecode = seq ? 2 : 1; end
            if (vec == 8) fin = i;
        end
    endtask

    // Random run: prefix, 7, 0..7, 0, tail; optional bad gate / holds / sequence
    task automatic build(input bit bad_gate, input bit bad_step, input bit bad_seq);
        int p0, p1, v, j, n;
        pats.delete(); holds.delete();
        tt = 8'h80;
        if (bad_gate) begin tt = 8'($urandom); tt[0] = 1'b0; end
        p0 = int'($urandom_range(1, 6));
        do p1 = int'($urandom_range(0, 6)); while (p1 == p0);
        pats.push_back(p0); holds.push_back(int'($urandom_range(1, 4)));
        pats.push_back(p1); holds.push_back(int'($urandom_range(1, 4)));
        pats.push_back(7);  holds.push_back(int'($urandom_range(1, 4)));
        for (int k = 0; k < 9; k++) begin
            pats.push_back(k % 8);
            holds.push_back(bad_step ? int'($urandom_range(1, 4)) : int'(STEP));
        end
        for (int k = 0; k < 3; k++) begin
            do v = int'($urandom_range(0, 7)); while (v == pats[pats.size()-1]);
            pats.push_back(v); holds.push_back(int'(STEP));
        end
        if (bad_seq) begin
            n = int'($urandom_range(1, 2));
            repeat (n) begin
                j = 4 + int'($urandom_range(0, 7));
                do v = int'($urandom_range(0, 7)); while (v == pats[j-1] || v == pats[j+1]);
                pats[j] = v;
            end
        end
    endtask

    task automatic run_list(input string nm, input bit mid_start, input int abort_vec,
                            output bit aborted);
        int a, fin, ecnt, ecode, first_done, t_fin;
        model(a, fin, ecnt, ecode);
        aborted = 1'b0;
        drive_pat(pats[0]);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({nm, "_start_busy"}, 32'(busy), 1);
        check_eq({nm, "_start_done"}, 32'(done), 0);
        first_done = -1;
        t_fin = -1;
        for (int k = 0; k < pats.size(); k++) begin
            drive_pat(pats[k]);
            if (k == fin) t_fin = cyc;
            if (mid_start && k == a + 4) start = 1'b1;
            for (int h = 0; h < holds[k]; h++) begin
                tick();
                start = 1'b0;
                if (done && first_done < 0) first_done = cyc;
                if (abort_vec != 0 && int'(vec_cnt) == abort_vec) begin
                    aborted = 1'b1;
                    return;
                end
            end
        end
        for (int w = 0; w < 40 && first_done < 0; w++) begin
            tick();
            if (done) first_done = cyc;
        end
        check_eq({nm, "_done_cycle"}, 32'(first_done), 32'(t_fin + 2));
        check_eq({nm, "_done"},     32'(done),     1);
        check_eq({nm, "_busy"},     32'(busy),     0);
        check_eq({nm, "_err_cnt"},  32'(err_cnt),  32'(ecnt));
        check_eq({nm, "_err_code"}, 32'(err_code), 32'(ecode));
        check_eq({nm, "_vec_cnt"},  32'(vec_cnt),  8);
        check_eq({nm, "_pass"},     32'(pass),     (ecnt == 0) ? 1 : 0);
    endtask

    task automatic check_all_zero(input string nm);
        check_eq({nm, "_busy"},     32'(busy),     0);
        check_eq({nm, "_done"},     32'(done),     0);
        check_eq({nm, "_pass"},     32'(pass),     0);
        check_eq({nm, "_err_cnt"},  32'(err_cnt),  0);
        check_eq({nm, "_vec_cnt"},  32'(vec_cnt),  0);
        check_eq({nm, "_err_code"}, 32'(err_code), 0);
    endtask

    initial begin
        bit ab;
        int s, first;
        rst = 1'b1; start = 1'b0; tt = 8'h80;
        drive_pat(0);
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Healthy sweep with an ignored start pulse mid-check
        build(1'b0, 1'b0, 1'b0);
        run_list("healthy", 1'b1, 0, ab);

        // OR gate in place of AND
        build(1'b0, 1'b0, 1'b0);
        tt = 8'hFE;
        run_list("or_gate", 1'b0, 0, ab);

        // Generator stepping every 3 cycles
        build(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < holds.size(); i++) holds[i] = 3;
        run_list("step3", 1'b0, 0, ab);

        // Pattern 100 skipped
        tt = 8'h80;
        pats  = '{3, 5, 7, 0, 1, 2, 3, 5, 6, 7, 0, 1, 4, 6};
        holds = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        run_list("skip", 1'b0, 0, ab);

        // Stimulus frozen at 010 after start
        tt = 8'h80;
        drive_pat(2);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
        first = -1;
        for (int w = 0; w < 40 && first < 0; w++) begin
            tick();
            if (done) first = cyc;
        end
        check_eq("stuck_done_cycle", 32'(first), 32'(s + 17));
        check_eq("stuck_err_cnt",  32'(err_cnt),  1);
        check_eq("stuck_err_code", 32'(err_code), 3);
        check_eq("stuck_vec_cnt",  32'(vec_cnt),  0);
        check_eq("stuck_pass",     32'(pass),     0);

        // Reset in the middle of a check with one logic error on 001
        build(1'b0, 1'b0, 1'b0);
        tt = 8'h82;
        run_list("mid", 1'b0, 4, ab);
        check_eq("mid_reached_vec4", 32'(ab), 1);
        check_eq("mid_err_cnt", 32'(err_cnt), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid_reset");
        build(1'b0, 1'b0, 1'b0);
        run_list("post_reset", 1'b0, 0, ab);

        // Randomized runs
        for (int r = 0; r < 14; r++) begin
            build(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_list($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 0, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/and3_sweep_checker.md
# and3_sweep_checker

Self-checking consumer stage placed directly downstream of the 3-bit stepping stimulus generator and the 3-input AND gate under test. It samples the stimulus bits `in0..in2` and the gate output `out`. It aligns to the start of a sweep, then checks three things over one full 000→111 sweep: every pattern increments by one, every pattern is held exactly `STEP` cycles, and the gate output equals the AND of the pattern. At the end it reports pass/fail, error count and error class.

## Interface
- `STEP`, 2, expected hold length of each pattern in clock cycles (≥1; matches the generator's step)
- `TIMEOUT`, 16, maximum cycles a pattern may remain unchanged before the stimulus is declared stuck (> `STEP`)
- `CNT_W`, 8, width of `err_cnt`
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in0`  in  1  stimulus MSB, pattern bit 2
- `in1`  in  1  stimulus bit 1
- `in2`  in  1  stimulus LSB, pattern bit 0
- `out`  in  1  output of the AND gate under test
- `start`  in  1  one-cycle request to begin a check, honoured in IDLE and DONE only
- `busy`  out  1  high in ALIGN and CHECK
- `done`  out  1  high while in DONE
- `pass`  out  1  `done && err_cnt == 0`
- `err_cnt`  out  CNT_W  errors counted this run, saturates at all-ones
- `vec_cnt`  out  4  patterns completed this run, 0..8
- `err_code`  out  2  most recent error class: 0 none, 1 logic mismatch, 2 sequence/step error, 3 timeout

## Operation
- Input stage: `pat <= {in0,in1,in2}`, `o_s <= out`, `pat_d <= pat`, every cycle. All checks use the registered values.
- Change event: `pat != pat_d`.
- `hold_cnt`:
  - loads 1 on a change event
  - otherwise increments, saturating at `TIMEOUT`
- FSM states and transitions:
  - IDLE: waits for `start`; the move to ALIGN clears `err_cnt`, `vec_cnt`, `err_code` and `hold_cnt`.
  - ALIGN: moves to CHECK on a change event with `pat_d==3'b111` and `pat==3'b000`.
  - CHECK: runs the per-cycle and per-change checks below.
  - DONE: holds all results; `start` restarts the run exactly as from IDLE.
- CHECK, every cycle: if `o_s != &pat` and the per-pattern mismatch flag is clear, count one error, set code 1 and set the flag. The flag clears on each change event. This gives at most one mismatch error per pattern.
- CHECK, on each change event:
  - If `pat != pat_d + 1` (mod 8) or `hold_cnt != STEP`, count one error and set code 2. Both failing together count as one error.
  - `vec_cnt` increments on every change event in CHECK.
  - The change that brings `vec_cnt` to 8 moves the FSM to DONE.
- Timeout: in ALIGN or CHECK, `hold_cnt == TIMEOUT` without a change counts one error, sets code 3 and moves to DONE.
- Same-cycle events: one counted error per cycle at most. The code takes the highest-priority class: timeout > sequence/step > mismatch.
- `start` in ALIGN or CHECK is ignored.
- Reset values, on the first clock edge with `rst` high, from any state:
  - FSM in IDLE
  - `busy`, `done`, `pass` = 0; `err_cnt`, `vec_cnt`, `err_code` = 0
  - `pat`, `pat_d` = 0; `hold_cnt` = 0; mismatch flag clear

## Timing
- Input sampling latency is 1 cycle: a stimulus change on edge N is seen as a change event at edge N+1.
- ALIGN→CHECK happens on the edge that registers the 111→000 event. That 000 cycle counts as hold cycle 1.
- With a healthy generator, CHECK lasts 8×`STEP` cycles; `done` rises on the edge after the final 111→000 change event is registered.
- `err_cnt`, `err_code` and `vec_cnt` update on the same edge the error or change is registered.
- `done`, `pass` and the counters stay stable in DONE until `start` or `rst`.

## Test plan
- **Healthy sweep:** `STEP`=2, generator step 2, true AND, `start` in IDLE -> ALIGN to CHECK on first 111→000, `done`=1 after 16 CHECK cycles, `pass`=1, `vec_cnt`=8, `err_cnt`=0, `err_code`=0.
- **Wrong gate:** OR gate in place of AND -> mismatches on 001,010,011,100,101,110 -> `err_cnt`=6, `err_code`=1, `pass`=0, `vec_cnt`=8.
- **Wrong step:** generator step 3 with `STEP`=2 -> 8 step errors -> `err_cnt`=8, `err_code`=2, `pass`=0.
- **Skipped pattern:** sequence 000,001,010,011,101,... -> one error at the 011→101 change, `err_code`=2; the run still ends in DONE once `vec_cnt` reaches 8.
- **Stuck stimulus:** pattern frozen at 010 after `start` -> ALIGN times out after 16 cycles -> `done`=1, `err_cnt`=1, `err_code`=3, `vec_cnt`=0.
- **Reset mid-check:** `rst` asserted with `vec_cnt`=4 and `err_cnt`=1 -> next edge all outputs 0, FSM in IDLE; a later `start` plus healthy sweep gives `pass`=1.
